// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: ROM request/response, redirect input and the decode-side valid/ready output.
interface inst_fetch_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32
);
   logic              rom_ce_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [INST_W-1:0] rom_inst_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [ADDR_W-1:0] out_pc_o;
   logic [INST_W-1:0] out_inst_o;
   logic              out_exc_o;

   modport master (
      output rom_ce_o, rom_addr_o, out_valid_o, out_pc_o, out_inst_o, out_exc_o,
      input  rom_inst_i, redirect_i, redirect_pc_i, out_ready_i
   );

   modport slave (
      input  rom_ce_o, rom_addr_o, out_valid_o, out_pc_o, out_inst_o, out_exc_o,
      output rom_inst_i, redirect_i, redirect_pc_i, out_ready_i
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM, queues {pc, inst} for decode, flushes on redirect.
// Optional INST_FETCH_MISALIGN_EN: misaligned fetch emits one exception marker and halts until redirect.
module inst_fetch #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       INST_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       QUEUE_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   inst_fetch_if.master bus
);
   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
`ifdef INST_FETCH_MISALIGN_EN
   localparam logic [ADDR_W-1:0] START_PC = RESET_PC;
`else
   localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ALIGN_MASK;
`endif

   logic [ADDR_W-1:0] pc;
   logic              run;
   logic              halted;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] pc_mem   [QUEUE_DEPTH];
   logic [INST_W-1:0] inst_mem [QUEUE_DEPTH];
`ifdef INST_FETCH_MISALIGN_EN
   logic              exc_mem  [QUEUE_DEPTH];
`endif

   logic              head_valid;
   logic              pop;
   logic              space;
   logic              fetch;
   logic              misalign;
   logic [ADDR_W-1:0] target;

   // Handshake, fetch qualification and redirect target shaping
   always_comb begin
      head_valid = 1'b0;
      pop        = 1'b0;
      space      = 1'b0;
      fetch      = 1'b0;
      misalign   = 1'b0;
      target     = '0;
      head_valid = (count != '0);
      pop        = head_valid & bus.out_ready_i;
      space      = (count < CNT_W'(QUEUE_DEPTH)) | pop;
      fetch      = run & space & ~bus.redirect_i & ~halted;
`ifdef INST_FETCH_MISALIGN_EN
      misalign   = fetch & (pc[1:0] != 2'b00);
      target     = bus.redirect_pc_i;
`else
      target     = bus.redirect_pc_i & ALIGN_MASK;
`endif
   end

   // PC, run/halt flags and queue pointers; redirect flushes any in-flight entries
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= START_PC;
         run    <= 1'b0;
         halted <= 1'b0;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         run <= 1'b1;
         if (bus.redirect_i) begin
            pc     <= target;
            halted <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (fetch) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               if (misalign) halted <= 1'b1;
               else          pc     <= pc + ADDR_W'(4);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(fetch) - CNT_W'(pop);
         end
      end
   end

   // Queue storage; stale contents are harmless because count gates visibility
   always_ff @(posedge clk) begin
      if (fetch) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= misalign ? '0 : bus.rom_inst_i;
`ifdef INST_FETCH_MISALIGN_EN
         exc_mem[wr_ptr]  <= misalign;
`endif
      end
   end

   assign bus.rom_ce_o    = fetch;
   assign bus.rom_addr_o  = pc;
   assign bus.out_valid_o = head_valid;
   assign bus.out_pc_o    = head_valid ? pc_mem[rd_ptr]   : '0;
   assign bus.out_inst_o  = head_valid ? inst_mem[rd_ptr] : '0;
`ifdef INST_FETCH_MISALIGN_EN
   assign bus.out_exc_o   = head_valid ? exc_mem[rd_ptr] : 1'b0;
`else
   assign bus.out_exc_o   = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations plus a per-cycle queue-based reference model.
module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
   } ent_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   inst_fetch_if #(.ADDR_W(32), .INST_W(32)) ifc ();

   inst_fetch #(
      .ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom_f = 32'h3401_1100;
         32'h0000_0004: rom_f = 32'h3402_0020;
         32'h0000_0008: rom_f = 32'h3403_FF00;
         default:       rom_f = a ^ 32'hC3C3_0000;
      endcase
   endfunction

   always_comb ifc.rom_inst_i = rom_f(ifc.rom_addr_o);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of fetched entries plus pc/run/halt
   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_run;
   bit          m_halt;
   bit          started;

   function automatic bit exp_fetch();
      bit room;
      room = (mq.size() < DEPTH) || (mq.size() > 0 && ifc.out_ready_i);
      return m_run && !m_halt && !ifc.redirect_i && room;
   endfunction

   function automatic logic [31:0] shape_pc(input logic [31:0] a);
`ifdef INST_FETCH_MISALIGN_EN
      return a;
`else
      return a & 32'hFFFF_FFFC;
`endif
   endfunction

   initial begin
      m_pc = '0; m_run = 0; m_halt = 0; started = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            m_pc    = shape_pc(RESET_PC);
            m_run   = 0;
            m_halt  = 0;
            started = 1;
         end else begin
            bit do_pop, do_fetch, mis;
            do_pop   = (mq.size() > 0) && ifc.out_ready_i;
            do_fetch = exp_fetch();
            mis      = 0;
`ifdef INST_FETCH_MISALIGN_EN
            mis = (m_pc[1:0] != 2'b00);
`endif
            if (ifc.redirect_i) begin
               mq.delete();
               m_pc   = shape_pc(ifc.redirect_pc_i);
               m_halt = 0;
            end else begin
               if (do_pop) void'(mq.pop_front());
               if (do_fetch) begin
                  if (mis) begin
                     mq.push_back('{pc: m_pc, inst: 32'h0, exc: 1'b1});
                     m_halt = 1;
                  end else begin
                     mq.push_back('{pc: m_pc, inst: rom_f(m_pc), exc: 1'b0});
                     m_pc = m_pc + 32'd4;
                  end
               end
            end
            m_run = 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("m_valid", ifc.out_valid_o, mq.size() != 0);
            chk("m_ce",    ifc.rom_ce_o, exp_fetch());
            chk("m_addr",  ifc.rom_addr_o, m_pc);
            if (mq.size() != 0) begin
               chk("m_pc",   ifc.out_pc_o,   mq[0].pc);
               chk("m_inst", ifc.out_inst_o, mq[0].inst);
               chk("m_exc",  ifc.out_exc_o,  mq[0].exc);
            end else begin
               chk("m_pc0",   ifc.out_pc_o,   0);
               chk("m_inst0", ifc.out_inst_o, 0);
               chk("m_exc0",  ifc.out_exc_o,  0);
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redirect_to(input logic [31:0] a);
      ifc.redirect_i    = 1'b1;
      ifc.redirect_pc_i = a;
      step();
      ifc.redirect_i    = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      ifc.out_ready_i   = 1'b1;
      ifc.redirect_i    = 1'b0;
      ifc.redirect_pc_i = '0;

      // Reset state and basic in-order streaming
      step(2);
      chk("rst_ce",    ifc.rom_ce_o, 0);
      chk("rst_valid", ifc.out_valid_o, 0);
      chk("rst_addr",  ifc.rom_addr_o, RESET_PC);
      chk("rst_pc",    ifc.out_pc_o, 0);
      chk("rst_inst",  ifc.out_inst_o, 0);
      chk("rst_exc",   ifc.out_exc_o, 0);
      rst = 1'b0;
      step();
      chk("t1_c1_ce",    ifc.rom_ce_o, 1);
      chk("t1_c1_valid", ifc.out_valid_o, 0);
      step();
      chk("t1_c2_valid", ifc.out_valid_o, 1);
      chk("t1_pc0",      ifc.out_pc_o, 32'h0);
      chk("t1_inst0",    ifc.out_inst_o, 32'h3401_1100);
      step();
      chk("t1_pc4",      ifc.out_pc_o, 32'h4);
      chk("t1_inst4",    ifc.out_inst_o, 32'h3402_0020);
      step();
      chk("t1_pc8",      ifc.out_pc_o, 32'h8);
      chk("t1_inst8",    ifc.out_inst_o, 32'h3403_FF00);

      // Back-pressure from reset: queue fills, PC holds, then drains in order
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      ifc.out_ready_i = 1'b0;
      step(3);
      chk("t2_ce_full",  ifc.rom_ce_o, 0);
      chk("t2_addr_hold", ifc.rom_addr_o, 32'h8);
      step(2);
      chk("t2_addr_hold2", ifc.rom_addr_o, 32'h8);
      ifc.out_ready_i = 1'b1;
      chk("t2_pc0", ifc.out_pc_o, 32'h0);
      step();
      chk("t2_pc4", ifc.out_pc_o, 32'h4);
      step();
      chk("t2_pc8", ifc.out_pc_o, 32'h8);
      step();
      chk("t2_pcC", ifc.out_pc_o, 32'hC);

      // Redirect while full flushes old entries
      ifc.out_ready_i = 1'b0;
      step(3);
      chk("t3_full_ce", ifc.rom_ce_o, 0);
      redirect_to(32'h100);
      chk("t3_n1_valid", ifc.out_valid_o, 0);
      chk("t3_n1_addr",  ifc.rom_addr_o, 32'h100);
      step();
      chk("t3_n2_valid", ifc.out_valid_o, 1);
      chk("t3_n2_pc",    ifc.out_pc_o, 32'h100);
      chk("t3_n2_inst",  ifc.out_inst_o, 32'hC3C3_0100);
      ifc.out_ready_i = 1'b1;
      step();
      chk("t3_next_pc",  ifc.out_pc_o, 32'h104);

      // PC wraps past the top of the address space
      redirect_to(32'hFFFF_FFFC);
      step();
      chk("t4_pc_top",  ifc.out_pc_o, 32'hFFFF_FFFC);
      step();
      chk("t4_pc_wrap", ifc.out_pc_o, 32'h0);

      // Misaligned redirect target
      redirect_to(32'h102);
      step();
`ifdef INST_FETCH_MISALIGN_EN
      chk("t5_pc",   ifc.out_pc_o, 32'h102);
      chk("t5_exc",  ifc.out_exc_o, 1);
      chk("t5_inst", ifc.out_inst_o, 0);
      step();
      chk("t5_halt_valid", ifc.out_valid_o, 0);
      chk("t5_halt_ce",    ifc.rom_ce_o, 0);
      step(3);
      chk("t5_halt_valid2", ifc.out_valid_o, 0);
      redirect_to(32'h200);
      step();
      chk("t5_resume_pc", ifc.out_pc_o, 32'h200);
`else
      chk("t5_pc",   ifc.out_pc_o, 32'h100);
      chk("t5_exc",  ifc.out_exc_o, 0);
      chk("t5_inst", ifc.out_inst_o, 32'hC3C3_0100);
`endif

      // Reset overrides a simultaneous redirect with a full queue
      ifc.out_ready_i = 1'b0;
      step(3);
      chk("t6_full_valid", ifc.out_valid_o, 1);
      rst = 1'b1;
      ifc.redirect_i    = 1'b1;
      ifc.redirect_pc_i = 32'h300;
      step();
      chk("t6_valid", ifc.out_valid_o, 0);
      chk("t6_ce",    ifc.rom_ce_o, 0);
      chk("t6_addr",  ifc.rom_addr_o, RESET_PC);
      rst = 1'b0;
      ifc.redirect_i = 1'b0;

      // Mixed back-pressure with a mid-stream redirect, checked by the model
      for (int i = 0; i < 40; i++) begin
         ifc.out_ready_i = ((i % 3) != 0);
         if (i == 20) begin
            ifc.redirect_i    = 1'b1;
            ifc.redirect_pc_i = 32'h40;
         end else begin
            ifc.redirect_i    = 1'b0;
         end
         step();
      end
      ifc.redirect_i = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
